// File: rtl/pp_pkg.sv
// Shared types and helpers for the partial-product engine.
// Holds the FSM state encoding and the per-mode row count.
package pp_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } pp_state_e;

   // Signed mode needs one extra constant row to correct the sign bits.
   function automatic int row_count(input int width, input logic signed_mode);
      return signed_mode ? width + 1 : width;
   endfunction

endpackage

// File: rtl/pp_row_gen.sv
// Combinational partial-product row former: unsigned AND rows or
// Baugh-Wooley signed rows (with the constant correction row) for one index.
module pp_row_gen
   import pp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int IDXW  = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]   a_reg,
   input  logic [WIDTH-1:0]   b_reg,
   input  logic [IDXW-1:0]    idx,
   input  logic               mode,
   output logic [2*WIDTH-1:0] row
);

   localparam logic [2*WIDTH-1:0] CORR_ROW =
      {1'b1, {(WIDTH-2){1'b0}}, 1'b1, {WIDTH{1'b0}}};

   logic             b_sel;
   logic             is_top;
   logic             is_corr;
   logic [WIDTH-1:0] gated;
   logic [WIDTH-1:0] inv_mask;
   logic [WIDTH-1:0] base;

   always_comb begin
      b_sel = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (idx == IDXW'(i)) b_sel = b_reg[i];
      end
   end

   for (genvar j = 0; j < WIDTH; j++) begin : g_gate
      assign gated[j] = a_reg[j] & b_sel;
   end

   assign is_top  = (idx == IDXW'(WIDTH - 1));
   assign is_corr = mode && (idx == IDXW'(WIDTH));

   // The top row inverts the low bits; every other row inverts only the MSB.
   always_comb begin
      inv_mask = '0;
      if (mode) begin
         if (is_top) inv_mask = {1'b0, {(WIDTH-1){1'b1}}};
         else        inv_mask = {1'b1, {(WIDTH-1){1'b0}}};
      end
   end

   assign base = gated ^ inv_mask;
   assign row  = is_corr ? CORR_ROW : ({{WIDTH{1'b0}}, base} << idx);

endmodule

// File: rtl/partial_product_engine.sv
// Streams the shifted partial-product rows of one operand pair per transaction,
// one row per accepted output handshake, with a two-state IDLE/EMIT controller.
module partial_product_engine
   import pp_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int IDXW  = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] pp_row,
   output logic [IDXW-1:0]    pp_idx,
   output logic               pp_last,
   output logic               busy
);

   localparam logic [IDXW-1:0] LAST_U = IDXW'(row_count(WIDTH, 1'b0) - 1);
   localparam logic [IDXW-1:0] LAST_S = IDXW'(row_count(WIDTH, 1'b1) - 1);

   pp_state_e          state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               mode_q;
   logic [IDXW-1:0]    idx_q;
   logic [2*WIDTH-1:0] row_w;
   logic               emit;
   logic               last_w;

   assign emit   = (state_q == ST_EMIT);
   assign last_w = (idx_q == (mode_q ? LAST_S : LAST_U));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  mode_q  <= signed_mode;
                  idx_q   <= '0;
                  state_q <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  if (last_w) begin
                     idx_q   <= '0;
                     state_q <= ST_IDLE;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   pp_row_gen #(
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
   ) u_row_gen (
      .a_reg (a_q),
      .b_reg (b_q),
      .idx   (idx_q),
      .mode  (mode_q),
      .row   (row_w)
   );

   // Outputs are masked in IDLE so nothing stale is visible between pairs.
   assign in_ready  = !emit;
   assign out_valid = emit;
   assign busy      = emit;
   assign pp_row    = emit ? row_w : '0;
   assign pp_idx    = emit ? idx_q : '0;
   assign pp_last   = emit && last_w;

endmodule

// File: doc/partial_product_engine.md
PARTIAL_PRODUCT_ENGINE -- requirements
Module: partial_product_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits; legal range 4..32.
REQ-002 SHALL have derived localparam IDXW = $clog2(WIDTH+1), meaning row-index width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  engine accepts an operand pair.
REQ-007 SHALL have port a  input  WIDTH  multiplicand.
REQ-008 SHALL have port b  input  WIDTH  multiplier.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement operands (Baugh-Wooley); 0 = unsigned.
REQ-010 SHALL have port out_valid  output  1  pp_row, pp_idx and pp_last are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the current row.
REQ-012 SHALL have port pp_row  output  2*WIDTH  shifted partial-product row.
REQ-013 SHALL have port pp_idx  output  IDXW  row number, 0-based.
REQ-014 SHALL have port pp_last  output  1  current row is the final row of this operand pair.
REQ-015 SHALL have port busy  output  1  an operand pair is held (FSM not IDLE).

Function
REQ-016 SHALL implement a two-state FSM, IDLE and EMIT.
REQ-017 IDLE behaviour: in_ready=1, out_valid=0.
- on in_valid&&in_ready: register a, b and signed_mode; set idx=0; go to EMIT.
REQ-018 EMIT behaviour: in_ready=0, out_valid=1; idx advances by one on each out_valid&&out_ready.
REQ-019 SHALL drive out_valid high in the cycle after input acceptance (1-cycle latency); one row is emitted per accepted handshake cycle.
REQ-020 Unsigned row count and content: WIDTH rows; row i = ({WIDTH zeros, a_reg & {WIDTH{b_reg[i]}}}) << i.
REQ-021 Signed rows for i<WIDTH-1, before the << i shift:
- bits j<WIDTH-1 = a[j]&b[i];
- bit WIDTH-1 = ~(a[WIDTH-1]&b[i]).
REQ-022 Signed row i=WIDTH-1, before the << i shift:
- bits j<WIDTH-1 = ~(a[j]&b[i]);
- bit WIDTH-1 = a[WIDTH-1]&b[i].
REQ-023 Signed correction row: row WIDTH is a constant with only bits WIDTH and 2*WIDTH-1 set; signed mode therefore emits WIDTH+1 rows.
REQ-024 Sum property: the sum of all rows modulo 2^(2*WIDTH) SHALL equal the exact product, unsigned or two's-complement per mode.
REQ-025 pp_last SHALL be 1 only on row WIDTH-1 (unsigned) or row WIDTH (signed).
REQ-026 Acceptance of the pp_last row SHALL return the FSM to IDLE; in_ready rises the following cycle, with no same-cycle overlap of output and input handshakes.
REQ-027 While out_valid && !out_ready, pp_row, pp_idx and pp_last SHALL hold stable for any number of stall cycles.
REQ-028 Changes on a, b or signed_mode while busy SHALL have no effect.
REQ-029 Zero operand: all-zero rows are still emitted; row count depends on mode only.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE, idx=0, out_valid=0, busy=0, pp_row=0, pp_idx=0, pp_last=0; in_ready=1 after release.
REQ-031 Reset during EMIT SHALL discard the pending operand pair; no further rows for it.

Structure
REQ-032 Package pp_pkg SHALL hold the FSM state enum and a function for row count per mode.
REQ-033 Sub-module pp_row_gen SHALL be the combinational row former (inputs a_reg, b_reg, idx, mode; output row), wrapping the single-bit gating of the previous partial-product block.

Verification
REQ-034 Unsigned, WIDTH=16, a=0x1234, b=0x0005, out_ready=1 -> 16 rows; row0=0x00001234, row1=0, row2=0x000048D0, rows3..15=0; pp_last on idx 15; sum 0x00005B04.
REQ-035 Signed, WIDTH=4, a=0xD (-3), b=0x5 -> rows 0x05, 0x10, 0x14, 0x38, 0x90; pp_last on idx 4; sum mod 256 = 0xF1 (-15).
REQ-036 Backpressure: out_ready low 3 cycles at idx 2 -> pp_row/pp_idx stable for all 3 cycles; no row lost or duplicated.
REQ-037 rst pulse at idx 5 of an unsigned pair -> out_valid=0 at once; after release a new pair starts at idx 0 with its own rows.
REQ-038 Back-to-back pairs with in_valid held high -> in_ready high exactly one cycle after each pp_last acceptance.
REQ-039 Random regression, WIDTH 8 and 16, both modes -> row sum matches the reference product for 10k pairs.
